fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences the combinational instruction memory. Each cycle it presents a word address, captures the returned instruction with its PC into a 2-entry buffer, and hands instructions to decode over a valid/ready handshake. It applies branch/jump redirects, halt requests and out-of-range detection. It sits between the instruction memory and the decode stage of the single-issue MIPS datapath.

Parameters:
MEM_WORDS, 128, number of instruction words implemented; a word index at or above this is out of range.
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
BUF_DEPTH, 2, fetch buffer entries; only 2 is supported.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  asynchronous, active-low reset.
imem_addr  output  32  byte address to instruction memory; equals the PC register; bits [1:0] always 0.
imem_instr  input  32  instruction memory read data; combinational from imem_addr within the same cycle.
out_valid  output  1  buffer head holds an instruction.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  32  head instruction.
out_pc  output  32  byte address of the head instruction.
redirect_valid  input  1  one-cycle pulse: branch/jump taken.
redirect_target  input  32  byte target for the redirect.
halt_req  input  1  level: stop fetching.
halted  output  1  in HALT state and buffer empty.
fault  output  1  sticky: out-of-range PC or misaligned redirect.

Behaviour:
- Reset (Rst=0, asynchronous):
  - PC=RESET_PC; state=RUN; buffer empty.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0.
- States: RUN, HALT, FAULT (shared encoding).
- Fetch: in RUN, fetch when the buffer is not full, or when it is full and a pop occurs this cycle.
  - A fetch pushes {imem_instr, PC} and sets PC=PC+4; the sum wraps mod 2^32.
  - All outputs come from registers. An instruction fetched in cycle N is visible at out_* in cycle N+1.
  - With out_ready held high, throughput is 1 instruction per cycle.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_instr and out_pc stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on redirect or reset.
- Redirect (redirect_valid=1):
  - Highest priority; overrides fetch, halt_req and HALT.
  - A transfer in the same cycle completes normally.
  - The buffer is then flushed and nothing is pushed this cycle. Next state is RUN and PC=redirect_target.
  - If redirect_target[1:0]!=0, the flush still occurs, but state becomes FAULT and PC is unchanged.
- Halt: in RUN with halt_req=1 and no redirect, no fetch occurs this cycle.
  - State goes to HALT; the buffer drains normally.
  - halted=1 while in HALT with the buffer empty.
  - halt_req deasserting in HALT with no redirect returns to RUN and resumes at the held PC.
- Out of range: in RUN, a fetch is due while PC[31:2] >= MEM_WORDS.
  - No push occurs; state becomes FAULT and fault=1.
  - Buffered entries still drain.
- FAULT: absorbing until reset. No fetches; redirect and halt_req are ignored.
- Simultaneous events:
  - Push and pop in the same cycle keep the occupancy unchanged.
  - redirect_valid and halt_req together: the redirect applies, and halt_req takes effect the next cycle.
- Reset mid-operation discards buffered instructions immediately; no partial transfer is reported.

Decomposition:
- fetch_pkg holds the state encoding {RUN, HALT, FAULT}, the PC increment constant 4, and the alignment mask.
- Sub-module fetch_buffer: 2-entry FIFO of {instr[31:0], pc[31:0]}.
  - Ports: push, pop, flush, full, empty, head.
  - Flush wins over push; pop is applied before flush within the cycle.
- The top level holds the PC, the FSM and the fault logic.

Test Plan:
- Reset release, memory words 0..5 preloaded, out_ready=1 -> out_pc 0,4,8,12,16,20 on consecutive cycles from cycle 1; out_instr matches memory; halted=0, fault=0.
- out_ready=0 for 5 cycles after the first valid -> out_pc holds 0 and the buffer fills to 2 entries (pc 0,4); imem_addr stalls at 8; after release, 0,4,8 are delivered with no gaps or duplicates.
- redirect_valid pulse with target 8 while the head is pc=12 and out_ready=1 -> pc=12 transfers, 16 is flushed; the next delivered pc=8 appears 2 cycles after the pulse.
- halt_req=1 while RUN -> buffer drains, halted=1 within 3 cycles, imem_addr frozen; halt_req=0 -> fetch resumes at the held PC. In a separate case, a redirect to 0x20 while HALT -> RUN resumes at 0x20.
- MEM_WORDS=6, run sequentially -> pcs 0..20 delivered, fault=1 when PC=24, no pc=24 delivered; a later redirect is ignored. A redirect target of 0x6 also raises fault.
- Rst low mid-stream with buffer full -> out_valid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - state_e       : sequencer states RUN / HALT / FAULT
//   - fetch_entry_t : one fetch-buffer entry {instr, pc}
//   - PC_INCR       : program-counter step between sequential words
//   - ALIGN_MASK    : byte-offset bits that must be zero in a word address
//   - is_aligned()  : word-alignment test for redirect targets
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// Small register FIFO holding fetched {instr, pc} pairs between the
// instruction memory and decode. The head is a register so the consumer sees
// registered data.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_din this cycle (caller guarantees a free slot)
//   i_pop       : drop the head this cycle (caller guarantees not empty)
//   i_flush     : discard all entries; overrides push, pop is irrelevant
//   i_din       : entry to write
//   o_full      : all DEPTH slots occupied
//   o_empty     : no entries
//   o_head      : oldest entry
// ----------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_entry [2];
  logic [CNT_W-1:0] r_count;
  logic             w_wr_slot1;

  // A push lands in slot 1 only if slot 0 is still occupied after any pop.
  assign w_wr_slot1 = (r_count == CNT_W'(2)) || ((r_count == CNT_W'(1)) && !i_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_entry[0] <= '0;
      r_entry[1] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      // Head update: a push into slot 0 takes precedence over the shift.
      if (i_push && !w_wr_slot1) begin
        r_entry[0] <= i_din;
      end else if (i_pop) begin
        r_entry[0] <= r_entry[1];
      end
      if (i_push && w_wr_slot1) begin
        r_entry[1] <= i_din;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_entry[0];

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter and drives the combinational instruction memory.
// Fetched words are buffered and handed to decode over valid/ready.
// Handles branch/jump redirects, halt requests and out-of-range faults.
// Ports:
//   Clk, Rst         : clock, asynchronous active-low reset
//   imem_addr        : byte address to instruction memory (the PC)
//   imem_instr       : instruction read data for imem_addr, same cycle
//   out_valid/ready  : decode handshake; out_instr/out_pc describe the head
//   redirect_valid   : one-cycle taken branch/jump, target redirect_target
//   halt_req         : level request to stop fetching
//   halted           : in HALT with nothing left to deliver
//   fault            : sticky out-of-range PC or misaligned redirect
// ----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault
);

  state_e       r_state;
  logic [31:0]  r_pc;

  state_e       w_state_next;
  logic [31:0]  w_pc_next;
  logic         w_push;
  logic         w_flush;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_slot_free;
  logic         w_in_range;
  fetch_entry_t w_head;
  fetch_entry_t w_din;

  assign w_pop       = !w_empty && out_ready;
  // A full buffer can still accept a fetch when its head leaves this cycle.
  assign w_slot_free = !w_full || w_pop;
  assign w_in_range  = {2'b00, r_pc[31:2]} < 32'(MEM_WORDS);
  assign w_din       = '{instr: imem_instr, pc: r_pc};

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    if (r_state != ST_FAULT && redirect_valid) begin
      // Redirect beats fetch and halt; a same-cycle transfer still completes.
      w_flush = 1'b1;
      if (is_aligned(redirect_target)) begin
        w_state_next = ST_RUN;
        w_pc_next    = redirect_target;
      end else begin
        w_state_next = ST_FAULT;
      end
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            w_state_next = ST_HALT;
          end else if (w_slot_free) begin
            if (w_in_range) begin
              w_push    = 1'b1;
              w_pc_next = r_pc + PC_INCR;
            end else begin
              w_state_next = ST_FAULT;
            end
          end
        end
        ST_HALT: begin
          if (!halt_req) w_state_next = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign halted    = (r_state == ST_HALT) && w_empty;
  assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        halt_req = 1'b0;

  // Main instance: 128 words
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted, fault;
  // Small instance: 6 words, exercises the out-of-range path
  logic [31:0] imem_addr_b, imem_instr_b, out_instr_b, out_pc_b;
  logic        out_valid_b, halted_b, fault_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  // Instruction memory contents as a function of word index
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return 32'h2400_0055 + {2'b00, w} * 32'h0001_0001;
  endfunction

  assign imem_instr   = mem_word(imem_addr[31:2]);
  assign imem_instr_b = mem_word(imem_addr_b[31:2]);

  fetch_sequencer #(.MEM_WORDS(128), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut (
    .Clk(Clk), .Rst(Rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted), .fault(fault)
  );

  fetch_sequencer #(.MEM_WORDS(6), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b), .out_pc(out_pc_b),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted_b), .fault(fault_b)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves Rst released just after an edge; the next edge is fetch cycle 0.
  task automatic do_reset(input logic rdy);
    out_ready = rdy; redirect_valid = 1'b0; halt_req = 1'b0; redirect_target = 32'd0;
    Rst = 1'b0;
    tick(); tick();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 Rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", out_instr); else n_pass++;
    n_total++; if (out_pc !== 32'd0) $display("FAIL reset_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (imem_addr !== 32'd0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      $display("xfer pc=%h instr=%h valid=%b", out_pc, out_instr, out_valid);
      n_total++; if (out_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (out_pc !== 32'(k * 4)) $display("FAIL seq_pc[%0d]: got %h want %h", k, out_pc, 32'(k * 4)); else n_pass++;
      n_total++; if (out_instr !== mem_word(30'(k))) $display("FAIL seq_instr[%0d]: got %h want %h", k, out_instr, mem_word(30'(k))); else n_pass++;
      n_total++; if (out_pc_b !== 32'(k * 4)) $display("FAIL seq_pc_b[%0d]: got %h want %h", k, out_pc_b, 32'(k * 4)); else n_pass++;
      n_total++; if (fault_b !== 1'b0) $display("FAIL seq_fault_b[%0d]: got %b want 0", k, fault_b); else n_pass++;
    end
    tick();
    n_total++; if (out_pc !== 32'd24) $display("FAIL seq_pc6: got %h want 00000018", out_pc); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL seq_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL seq_fault: got %b want 0", fault); else n_pass++;
    n_total++; if (fault_b !== 1'b1) $display("FAIL oor_fault: got %b want 1", fault_b); else n_pass++;
    n_total++; if (out_valid_b !== 1'b0) $display("FAIL oor_valid: got %b want 0", out_valid_b); else n_pass++;
    n_total++; if (imem_addr_b !== 32'd24) $display("FAIL oor_addr: got %h want 00000018", imem_addr_b); else n_pass++;
  endtask

  task automatic test_out_of_range_sticky();
    redirect_valid = 1'b1; redirect_target = 32'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_total++; if (fault_b !== 1'b1) $display("FAIL oor_sticky_fault: got %b want 1", fault_b); else n_pass++;
    n_total++; if (imem_addr_b !== 32'd24) $display("FAIL oor_sticky_addr: got %h want 00000018", imem_addr_b); else n_pass++;
    n_total++; if (out_valid_b !== 1'b0) $display("FAIL oor_sticky_valid: got %b want 0", out_valid_b); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int v = 1; v <= 5; v++) begin
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", v, out_valid); else n_pass++;
      n_total++; if (out_pc !== 32'd0) $display("FAIL stall_pc[%0d]: got %h want 0", v, out_pc); else n_pass++;
      if (v >= 2) begin
        n_total++; if (imem_addr !== 32'd8) $display("FAIL stall_addr[%0d]: got %h want 8", v, imem_addr); else n_pass++;
      end
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      $display("xfer pc=%h instr=%h valid=%b", out_pc, out_instr, out_valid);
      n_total++; if (out_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b want 1", j, out_valid); else n_pass++;
      n_total++; if (out_pc !== 32'(j * 4)) $display("FAIL drain_pc[%0d]: got %h want %h", j, out_pc, 32'(j * 4)); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    tick(); tick(); tick(); tick();
    n_total++; if (out_pc !== 32'd12) $display("FAIL redir_head: got %h want 0000000c", out_pc); else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'd8;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'd8) $display("FAIL redir_addr: got %h want 8", imem_addr); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL redir_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 32'd8) $display("FAIL redir_pc: got %h want 8", out_pc); else n_pass++;
    n_total++; if (out_instr !== mem_word(30'd2)) $display("FAIL redir_instr: got %h want %h", out_instr, mem_word(30'd2)); else n_pass++;
    // Misaligned target: flush and fault, PC stays where it was
    redirect_valid = 1'b1; redirect_target = 32'd6;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (fault !== 1'b1) $display("FAIL misalign_fault: got %b want 1", fault); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL misalign_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'd12) $display("FAIL misalign_addr: got %h want 0000000c", imem_addr); else n_pass++;
    tick();
    n_total++; if (imem_addr !== 32'd12) $display("FAIL misalign_hold: got %h want 0000000c", imem_addr); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    tick(); tick(); tick();
    n_total++; if (out_pc !== 32'd8) $display("FAIL halt_pre_pc: got %h want 8", out_pc); else n_pass++;
    halt_req = 1'b1;
    tick();
    n_total++; if (halted !== 1'b1) $display("FAIL halt_halted: got %b want 1", halted); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'd12) $display("FAIL halt_addr: got %h want 0000000c", imem_addr); else n_pass++;
    tick();
    n_total++; if (imem_addr !== 32'd12) $display("FAIL halt_frozen: got %h want 0000000c", imem_addr); else n_pass++;
    halt_req = 1'b0;
    tick();
    n_total++; if (halted !== 1'b0) $display("FAIL unhalt_halted: got %b want 0", halted); else n_pass++;
    tick();
    n_total++; if (out_pc !== 32'd12) $display("FAIL resume_pc: got %h want 0000000c", out_pc); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL resume_valid: got %b want 1", out_valid); else n_pass++;
    // Halt again, then redirect out of HALT with halt_req still high
    halt_req = 1'b1;
    tick();
    n_total++; if (halted !== 1'b1) $display("FAIL halt2_halted: got %b want 1", halted); else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (halted !== 1'b0) $display("FAIL halt_redir_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (imem_addr !== 32'h20) $display("FAIL halt_redir_addr: got %h want 00000020", imem_addr); else n_pass++;
    tick();
    n_total++; if (halted !== 1'b1) $display("FAIL halt_after_redir: got %b want 1", halted); else n_pass++;
    halt_req = 1'b0;
    tick(); tick();
    n_total++; if (out_pc !== 32'h20) $display("FAIL redir_resume_pc: got %h want 00000020", out_pc); else n_pass++;
    n_total++; if (out_instr !== mem_word(30'd8)) $display("FAIL redir_resume_instr: got %h want %h", out_instr, mem_word(30'd8)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick(); tick();
    Rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'd0) $display("FAIL midrst_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (out_pc !== 32'd0) $display("FAIL midrst_pc: got %h want 0", out_pc); else n_pass++;
    out_ready = 1'b1;
    tick();
    Rst = 1'b1;
    tick();
    n_total++; if (out_pc !== 32'd0 || out_valid !== 1'b1) $display("FAIL restart_pc0: got pc=%h v=%b want pc=0 v=1", out_pc, out_valid); else n_pass++;
    tick();
    n_total++; if (out_pc !== 32'd4) $display("FAIL restart_pc4: got %h want 4", out_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_out_of_range_sticky();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
